// File: rtl/treat_store_pkg.sv
// Shared constants for the MEM-stage store path: widths, store opcodes,
// FSM state encoding and the request legality check.
package treat_store_pkg;

  localparam int DWIDTH       = 32;
  localparam int AWIDTH       = 32;
  localparam int OPCODE_WIDTH = 6;

  localparam logic [OPCODE_WIDTH-1:0] STORE_BYTE = 6'h28;
  localparam logic [OPCODE_WIDTH-1:0] STORE_HALF = 6'h29;
  localparam logic [OPCODE_WIDTH-1:0] STORE_WORD = 6'h2b;

  typedef enum logic [2:0] {
    TS_IDLE  = 3'd0,
    TS_READ  = 3'd1,
    TS_MERGE = 3'd2,
    TS_WRITE = 3'd3,
    TS_ERR   = 3'd4
  } ts_state_e;

  // True only for a known store opcode at an address its size allows.
  function automatic logic store_ok(input logic [OPCODE_WIDTH-1:0] opcode,
                                    input logic [1:0] lane);
    case (opcode)
      STORE_WORD: store_ok = (lane == 2'b00);
      STORE_HALF: store_ok = ~lane[0];
      STORE_BYTE: store_ok = 1'b1;
      default:    store_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge of store data into a memory word (little-endian
// lanes). Kept standalone so a store-to-load forwarding path can reuse it.
module store_merge
  import treat_store_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [1:0]              lane,
  input  logic [DWIDTH-1:0]       store_data,
  input  logic [DWIDTH-1:0]       rdata,
  output logic [DWIDTH-1:0]       merged
);

  always_comb begin
    merged = rdata;
    case (opcode)
      STORE_BYTE: merged[{lane, 3'b000} +: 8] = store_data[7:0];
      STORE_HALF: begin
        if (lane[1]) merged[31:16] = store_data[15:0];
        else         merged[15:0]  = store_data[15:0];
      end
      STORE_WORD: merged = store_data;
      default:    merged = rdata;
    endcase
  end

endmodule

// File: rtl/treat_store.sv
// Store-path unit: SW writes directly, SB/SH read-modify-write the word,
// illegal requests pulse misaligned without touching memory.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   TS_IDLE  | waiting for a request; only state that samples valid
//   TS_READ  | read strobe for the word holding the target lanes
//   TS_MERGE | read data returns; merged word captured into wdata
//   TS_WRITE | write strobe and done pulse
//   TS_ERR   | rejected request; misaligned pulse, no memory access
module treat_store
  import treat_store_pkg::*;
(
  input  logic                    ts_i_clk,
  input  logic                    ts_i_rst,
  input  logic                    ts_i_valid,
  input  logic [OPCODE_WIDTH-1:0] ts_i_opcode,
  input  logic [AWIDTH-1:0]       ts_i_addr,
  input  logic [DWIDTH-1:0]       ts_i_store_data,
  input  logic [DWIDTH-1:0]       ts_i_mem_rdata,
  output logic                    ts_o_busy,
  output logic [AWIDTH-1:0]       ts_o_mem_addr,
  output logic                    ts_o_mem_rd,
  output logic                    ts_o_mem_wr,
  output logic [DWIDTH-1:0]       ts_o_mem_wdata,
  output logic                    ts_o_done,
  output logic                    ts_o_misaligned
);

  ts_state_e               state_q, state_d;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [AWIDTH-1:0]       addr_q;
  logic [DWIDTH-1:0]       data_q;
  logic [DWIDTH-1:0]       wdata_q;
  logic [DWIDTH-1:0]       merged;
  logic                    accept;
  logic                    mem_phase;

  store_merge u_merge (
    .opcode     (op_q),
    .lane       (addr_q[1:0]),
    .store_data (data_q),
    .rdata      (ts_i_mem_rdata),
    .merged     (merged)
  );

  assign accept = (state_q == TS_IDLE) && ts_i_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      TS_IDLE: begin
        if (ts_i_valid) begin
          if (!store_ok(ts_i_opcode, ts_i_addr[1:0])) state_d = TS_ERR;
          else if (ts_i_opcode == STORE_WORD)         state_d = TS_WRITE;
          else                                        state_d = TS_READ;
        end
      end
      TS_READ:  state_d = TS_MERGE;
      TS_MERGE: state_d = TS_WRITE;
      TS_WRITE: state_d = TS_IDLE;
      TS_ERR:   state_d = TS_IDLE;
      default:  state_d = TS_IDLE;
    endcase
  end

  always_ff @(posedge ts_i_clk) begin
    if (ts_i_rst) begin
      state_q <= TS_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= ts_i_opcode;
        addr_q  <= ts_i_addr;
        data_q  <= ts_i_store_data;
        wdata_q <= ts_i_store_data;
      end
      if (state_q == TS_MERGE) wdata_q <= merged;
    end
  end

  // Memory-side outputs come only from state and latched registers.
  assign mem_phase       = (state_q == TS_READ) || (state_q == TS_MERGE) ||
                           (state_q == TS_WRITE);
  assign ts_o_busy       = (state_q != TS_IDLE);
  assign ts_o_mem_addr   = mem_phase ? {addr_q[AWIDTH-1:2], 2'b00} : '0;
  assign ts_o_mem_rd     = (state_q == TS_READ);
  assign ts_o_mem_wr     = (state_q == TS_WRITE);
  assign ts_o_mem_wdata  = (state_q == TS_WRITE) ? wdata_q : '0;
  assign ts_o_done       = (state_q == TS_WRITE);
  assign ts_o_misaligned = (state_q == TS_ERR);

endmodule

// File: tb/tb_treat_store.sv
// Directed bench for treat_store with a one-word synchronous memory model.
module tb_treat_store;
  import treat_store_pkg::*;

  localparam logic [5:0] LOAD_WORD = 6'h23;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [5:0]  opcode = '0;
  logic [31:0] addr = '0;
  logic [31:0] sdata = '0;
  logic [31:0] mem_rdata = '0;
  logic        busy, mem_rd, mem_wr, done, misaligned;
  logic [31:0] mem_addr, mem_wdata;

  logic [31:0] mem_word = 32'h1122_3344;
  logic [31:0] last_wdata = '0;
  logic [31:0] last_waddr = '0;
  int          wr_count = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  treat_store dut (
    .ts_i_clk        (clk),
    .ts_i_rst        (rst),
    .ts_i_valid      (valid),
    .ts_i_opcode     (opcode),
    .ts_i_addr       (addr),
    .ts_i_store_data (sdata),
    .ts_i_mem_rdata  (mem_rdata),
    .ts_o_busy       (busy),
    .ts_o_mem_addr   (mem_addr),
    .ts_o_mem_rd     (mem_rd),
    .ts_o_mem_wr     (mem_wr),
    .ts_o_mem_wdata  (mem_wdata),
    .ts_o_done       (done),
    .ts_o_misaligned (misaligned)
  );

  always #5 clk = ~clk;

  // Memory: read data one cycle after rd; writes recorded for checking.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem_word;
    if (mem_wr) begin
      last_wdata <= mem_wdata;
      last_waddr <= mem_addr;
      wr_count   <= wr_count + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one accept edge; returns sampled in cycle T+1.
  task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    opcode = op; addr = a; sdata = d; valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++; if ({busy, mem_rd, mem_wr, done, misaligned} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {busy, mem_rd, mem_wr, done, misaligned}); end
    n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_buses: got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sw();
    int wc;
    wc = wr_count;
    send(STORE_WORD, 32'h100, 32'hDEAD_BEEF);
    n_checks++; if ({busy, mem_wr, done, mem_rd} !== 4'b1110) begin n_fail++; $display("FAIL sw_strobes: got busy/wr/done/rd=%b want 1110", {busy, mem_wr, done, mem_rd}); end
    n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL sw_addr: got %h want 00000100", mem_addr); end
    n_checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_wdata: got %h want deadbeef", mem_wdata); end
    tick();
    n_checks++; if ({busy, mem_wr, mem_rd} !== 3'b000) begin n_fail++; $display("FAIL sw_idle: got busy/wr/rd=%b want 000", {busy, mem_wr, mem_rd}); end
    n_checks++; if (wr_count !== wc + 1) begin n_fail++; $display("FAIL sw_wrcount: got %0d want %0d", wr_count, wc + 1); end
  endtask

  task automatic test_sb_lanes();
    logic [31:0] addrs [4] = '{32'h203, 32'h200, 32'h201, 32'h202};
    logic [31:0] exps  [4] = '{32'hAA22_3344, 32'h1122_33AA, 32'h1122_AA44, 32'h11AA_3344};
    for (int i = 0; i < 4; i++) begin
      mem_word = 32'h1122_3344;
      send(STORE_BYTE, addrs[i], 32'h0000_00AA);
      n_checks++; if ({mem_rd, mem_wr, busy} !== 3'b101 || mem_addr !== 32'h200) begin n_fail++; $display("FAIL sb_read[%0d]: got rd/wr/busy=%b addr=%h want 101 00000200", i, {mem_rd, mem_wr, busy}, mem_addr); end
      tick();
      n_checks++; if ({mem_rd, mem_wr, busy} !== 3'b001) begin n_fail++; $display("FAIL sb_merge[%0d]: got rd/wr/busy=%b want 001", i, {mem_rd, mem_wr, busy}); end
      tick();
      n_checks++; if (mem_wr !== 1'b1 || done !== 1'b1 || mem_wdata !== exps[i] || mem_addr !== 32'h200) begin n_fail++; $display("FAIL sb_write[%0d]: got wr=%b done=%b wdata=%h addr=%h want 1 1 %h 00000200", i, mem_wr, done, mem_wdata, mem_addr, exps[i]); end
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sb_idle[%0d]: got busy=%b want 0", i, busy); end
    end
  endtask

  task automatic test_sh();
    logic [31:0] addrs [2] = '{32'h302, 32'h300};
    logic [31:0] exps  [2] = '{32'hBEEF_3344, 32'h1122_BEEF};
    for (int i = 0; i < 2; i++) begin
      mem_word = 32'h1122_3344;
      send(STORE_HALF, addrs[i], 32'hFFFF_BEEF);
      n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 32'h300) begin n_fail++; $display("FAIL sh_read[%0d]: got rd=%b addr=%h want 1 00000300", i, mem_rd, mem_addr); end
      tick(); tick();
      n_checks++; if (mem_wr !== 1'b1 || mem_wdata !== exps[i]) begin n_fail++; $display("FAIL sh_write[%0d]: got wr=%b wdata=%h want 1 %h", i, mem_wr, mem_wdata, exps[i]); end
      tick();
    end
  endtask

  task automatic test_reject();
    logic [5:0]  ops   [3] = '{STORE_HALF, STORE_WORD, LOAD_WORD};
    logic [31:0] addrs [3] = '{32'h101, 32'h102, 32'h100};
    int wc;
    for (int i = 0; i < 3; i++) begin
      wc = wr_count;
      send(ops[i], addrs[i], 32'h1234_5678);
      n_checks++; if ({misaligned, busy, mem_rd, mem_wr, done} !== 5'b11000 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL rej_err[%0d]: got mis/busy/rd/wr/done=%b addr=%h want 11000 0", i, {misaligned, busy, mem_rd, mem_wr, done}, mem_addr); end
      tick();
      n_checks++; if ({misaligned, busy, mem_rd, mem_wr} !== 4'b0000) begin n_fail++; $display("FAIL rej_idle[%0d]: got mis/busy/rd/wr=%b want 0000", i, {misaligned, busy, mem_rd, mem_wr}); end
      n_checks++; if (wr_count !== wc) begin n_fail++; $display("FAIL rej_nowrite[%0d]: got %0d writes want %0d", i, wr_count, wc); end
    end
  endtask

  task automatic test_busy_hold();
    int wc;
    wc = wr_count;
    mem_word = 32'h1122_3344;
    send(STORE_BYTE, 32'h201, 32'h0000_00AA);
    opcode = STORE_WORD; addr = 32'h400; sdata = 32'hCAFE_F00D; valid = 1'b1;
    tick();
    tick();
    n_checks++; if (mem_wr !== 1'b1 || mem_wdata !== 32'h1122_AA44 || mem_addr !== 32'h200) begin n_fail++; $display("FAIL hold_first: got wr=%b wdata=%h addr=%h want 1 1122aa44 00000200", mem_wr, mem_wdata, mem_addr); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_idle: got busy=%b want 0", busy); end
    tick();
    valid = 1'b0;
    n_checks++; if (mem_wr !== 1'b1 || mem_wdata !== 32'hCAFE_F00D || mem_addr !== 32'h400) begin n_fail++; $display("FAIL hold_second: got wr=%b wdata=%h addr=%h want 1 cafef00d 00000400", mem_wr, mem_wdata, mem_addr); end
    tick();
    n_checks++; if (wr_count !== wc + 2 || last_wdata !== 32'hCAFE_F00D || last_waddr !== 32'h400) begin n_fail++; $display("FAIL hold_landed: got %0d writes last=%h@%h want %0d cafef00d@00000400", wr_count, last_wdata, last_waddr, wc + 2); end
  endtask

  task automatic test_reset_mid();
    int wc;
    wc = wr_count;
    mem_word = 32'h1122_3344;
    send(STORE_BYTE, 32'h202, 32'h0000_0055);
    tick();
    n_checks++; if ({busy, mem_rd, mem_wr} !== 3'b100) begin n_fail++; $display("FAIL rstmid_merge: got busy/rd/wr=%b want 100", {busy, mem_rd, mem_wr}); end
    rst = 1'b1;
    tick();
    n_checks++; if ({busy, mem_rd, mem_wr, done, misaligned} !== 5'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_outs: got flags=%b addr=%h wdata=%h want 0", {busy, mem_rd, mem_wr, done, misaligned}, mem_addr, mem_wdata); end
    rst = 1'b0;
    tick(); tick();
    n_checks++; if (wr_count !== wc) begin n_fail++; $display("FAIL rstmid_nowrite: got %0d writes want %0d", wr_count, wc); end
    send(STORE_WORD, 32'h500, 32'h1234_5678);
    n_checks++; if (mem_wr !== 1'b1 || mem_wdata !== 32'h1234_5678 || mem_addr !== 32'h500) begin n_fail++; $display("FAIL rstmid_sw: got wr=%b wdata=%h addr=%h want 1 12345678 00000500", mem_wr, mem_wdata, mem_addr); end
    tick();
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb_lanes();
    test_sh();
    test_reject();
    test_busy_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
